vga_timing_receiver: RTL

//  Sink-side counterpart of the VGA timing generator. Consumes HS/VS/BLANK_N/RGB on the

---
 rtl/vga_timing_receiver.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: measures HS/VS/BLANK_N timing against an expected mode,
// locks after consecutive matching frames and emits a qualified pixel stream.
module vga_timing_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank_n,
  input  logic [23:0]   vga_rgb,
  output logic          pix_valid,
  output logic [23:0]   pix_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          locked,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_h_sync,
  output logic [CW-1:0] meas_h_active,
  output logic [CW-1:0] meas_v_total,
  output logic [CW-1:0] meas_v_sync,
  output logic [CW-1:0] meas_v_active,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_e;

  localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C   = CW'(H_SYNC);
  localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_SYNC_C   = CW'(V_SYNC);
  localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] EOL_X      = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] TO_LIM     = CW'(2 * H_TOTAL - 1);
  localparam logic [7:0]    LOCK_N     = 8'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  // Input sample stage and one-cycle-delayed copies for edge detection
  logic hs_q, vs_q, blank_q, hs_dq, vs_dq, blank_dq;
  logic [23:0] rgb_q;

  state_e        state_q, state_d;
  logic [7:0]    good_q, good_d, err_q, err_d;
  logic          locked_q, locked_d, frame_bad_q, frame_bad_d, lact_q, lact_d;
  logic [CW-1:0] hcnt_q, hcnt_d, hlow_q, hlow_d, hact_q, hact_d;
  logic [CW-1:0] vlines_q, vlines_d, vsl_q, vsl_d, vact_q, vact_d;
  logic [CW-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [CW-1:0] mh_tot_q, mh_tot_d, mh_sync_q, mh_sync_d, mh_act_q, mh_act_d;
  logic [CW-1:0] mv_tot_q, mv_tot_d, mv_sync_q, mv_sync_d, mv_act_q, mv_act_d;
  logic          pv_q, pv_d, sof_q, sof_d, eol_q, eol_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [23:0]   prgb_q, prgb_d;

  logic          hs_fall, vs_fall, blank_fall, timeout, h_line_bad, v_ok, frame_ok;
  logic [CW-1:0] h_tot_new, v_tot_new, v_act_new;

  assign hs_fall    = hs_dq & ~hs_q;
  assign vs_fall    = vs_dq & ~vs_q;
  assign blank_fall = blank_dq & ~blank_q;
  assign timeout    = ~hs_fall && (hcnt_q >= TO_LIM);

  // Values completed by this cycle's edges; a coincident HS fall lands in the
  // vertical counts before the VS fall consumes them.
  assign h_tot_new  = sat_inc(hcnt_q, 1'b1);
  assign v_tot_new  = sat_inc(vlines_q, hs_fall);
  assign v_act_new  = sat_inc(vact_q, hs_fall & lact_q);
  assign h_line_bad = hs_fall && (h_tot_new != H_TOTAL_C || hlow_q != H_SYNC_C ||
                                  (lact_q && hact_q != H_ACTIVE_C));
  assign v_ok       = (v_tot_new == V_TOTAL_C) && (vsl_q == V_SYNC_C) &&
                      (v_act_new == V_ACTIVE_C);
  assign frame_ok   = ~frame_bad_q & ~h_line_bad;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    hcnt_d      = hs_fall ? '0 : sat_inc(hcnt_q, 1'b1);
    hlow_d      = hs_fall ? CW'(1) : sat_inc(hlow_q, ~hs_q);
    hact_d      = hs_fall ? CW'(blank_q) : sat_inc(hact_q, blank_q);
    lact_d      = hs_fall ? blank_q : (lact_q | blank_q);
    mh_tot_d    = hs_fall ? h_tot_new : mh_tot_q;
    mh_sync_d   = hs_fall ? hlow_q : mh_sync_q;
    mh_act_d    = hs_fall ? hact_q : mh_act_q;

    vlines_d    = vs_fall ? '0 : v_tot_new;
    vsl_d       = vs_fall ? CW'(hs_fall) : sat_inc(vsl_q, hs_fall & ~vs_q);
    vact_d      = vs_fall ? '0 : v_act_new;
    mv_tot_d    = vs_fall ? v_tot_new : mv_tot_q;
    mv_sync_d   = vs_fall ? vsl_q : mv_sync_q;
    mv_act_d    = vs_fall ? v_act_new : mv_act_q;
    frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | h_line_bad);

    xcnt_d      = hs_fall ? CW'(blank_q) : sat_inc(xcnt_q, blank_q);
    ycnt_d      = vs_fall ? '0 : sat_inc(ycnt_q, blank_fall);
    px_d        = hs_fall ? '0 : xcnt_q;
    py_d        = vs_fall ? '0 : ycnt_q;
    pv_d        = locked_q & blank_q;
    sof_d       = pv_d && px_d == '0 && py_d == '0;
    eol_d       = pv_d && px_d == EOL_X;
    prgb_d      = rgb_q;

    state_d     = state_q;
    good_d      = good_q;
    locked_d    = locked_q;
    err_d       = err_q;
    if (timeout) begin
      state_d  = ST_SEARCH;
      locked_d = 1'b0;
      if (state_q == ST_LOCKED && err_q != 8'hFF) err_d = err_q + 8'd1;
    end else begin
      unique case (state_q)
        ST_SEARCH: if (vs_fall) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
        ST_MEASURE: if (vs_fall) begin
          if (frame_ok && v_ok) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= LOCK_N) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: if (h_line_bad || (vs_fall && !v_ok)) begin
          state_d  = ST_MEASURE;
          good_d   = '0;
          locked_d = 1'b0;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    if (rst) begin
      {hs_q, vs_q, blank_q, hs_dq, vs_dq, blank_dq} <= '0;
      rgb_q       <= '0;
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      err_q       <= '0;
      locked_q    <= 1'b0;
      frame_bad_q <= 1'b0;
      lact_q      <= 1'b0;
      {hcnt_q, hlow_q, hact_q, vlines_q, vsl_q, vact_q} <= '0;
      {xcnt_q, ycnt_q, px_q, py_q} <= '0;
      {mh_tot_q, mh_sync_q, mh_act_q, mv_tot_q, mv_sync_q, mv_act_q} <= '0;
      {pv_q, sof_q, eol_q} <= '0;
      prgb_q      <= '0;
    end else begin
      hs_q        <= vga_hs;
      vs_q        <= vga_vs;
      blank_q     <= vga_blank_n;
      rgb_q       <= vga_rgb;
      hs_dq       <= hs_q;
      vs_dq       <= vs_q;
      blank_dq    <= blank_q;
      state_q     <= state_d;
      good_q      <= good_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      frame_bad_q <= frame_bad_d;
      lact_q      <= lact_d;
      hcnt_q      <= hcnt_d;
      hlow_q      <= hlow_d;
      hact_q      <= hact_d;
      vlines_q    <= vlines_d;
      vsl_q       <= vsl_d;
      vact_q      <= vact_d;
      xcnt_q      <= xcnt_d;
      ycnt_q      <= ycnt_d;
      px_q        <= px_d;
      py_q        <= py_d;
      mh_tot_q    <= mh_tot_d;
      mh_sync_q   <= mh_sync_d;
      mh_act_q    <= mh_act_d;
      mv_tot_q    <= mv_tot_d;
      mv_sync_q   <= mv_sync_d;
      mv_act_q    <= mv_act_d;
      pv_q        <= pv_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      prgb_q      <= prgb_d;
    end
  end

  assign pix_valid     = pv_q;
  assign pix_rgb       = prgb_q;
  assign pix_x         = px_q;
  assign pix_y         = py_q;
  assign pix_sof       = sof_q;
  assign pix_eol       = eol_q;
  assign locked        = locked_q;
  assign meas_h_total  = mh_tot_q;
  assign meas_h_sync   = mh_sync_q;
  assign meas_h_active = mh_act_q;
  assign meas_v_total  = mv_tot_q;
  assign meas_v_sync   = mv_sync_q;
  assign meas_v_active = mv_act_q;
  assign err_cnt       = err_q;

endmodule
